// File: rtl/duty_cycle_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module   : duty_cycle_wave_gen
//  Purpose  : Prescaled-phase PWM generator with a shadowed duty register,
//             square-wave and DAC-code outputs, and a period-start strobe.
//  Revision : 1.0  initial release
// ============================================================================
module duty_cycle_wave_gen #(
    parameter int PHASE_STEPS = 100,
    parameter int RESET_DUTY  = 50,
    parameter int DAC_HIGH    = 4095
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] step_div,
    input  logic [6:0]  dutyCycle,
    output logic        wave_out,
    output logic [11:0] dac_out,
    output logic        period_start,
    output logic [6:0]  duty_latched
);

    localparam logic [6:0]  c_PHASE_STEPS = 7'(PHASE_STEPS);
    localparam logic [6:0]  c_PHASE_LAST  = 7'(PHASE_STEPS - 1);
    localparam logic [6:0]  c_RESET_DUTY  = 7'(RESET_DUTY);
    localparam logic [11:0] c_DAC_HIGH    = 12'(DAC_HIGH);

    // Declaration values match the reset values so nothing moves before reset.
    logic [15:0] r_pre_cnt      = '0;
    logic [6:0]  r_phase        = '0;
    logic [6:0]  r_duty_sh      = c_RESET_DUTY;
    logic        r_wave         = 1'b0;
    logic [11:0] r_dac          = '0;
    logic        r_period_start = 1'b0;

    logic       w_tick;
    logic       w_wrap;
    logic       w_high;
    logic [6:0] w_duty_req;

    // >= rather than == so a step_div shrink below the count wraps at once.
    assign w_tick     = enable && (r_pre_cnt >= step_div);
    assign w_wrap     = w_tick && (r_phase == c_PHASE_LAST);
    assign w_high     = (r_phase < r_duty_sh);
    assign w_duty_req = (dutyCycle > c_PHASE_STEPS) ? c_PHASE_STEPS : dutyCycle;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre_cnt      <= '0;
            r_phase        <= '0;
            r_duty_sh      <= c_RESET_DUTY;
            r_wave         <= 1'b0;
            r_dac          <= '0;
            r_period_start <= 1'b0;
        end else if (enable) begin
            r_wave         <= w_high;
            r_dac          <= w_high ? c_DAC_HIGH : 12'd0;
            r_period_start <= w_wrap;
            if (w_tick) begin
                r_pre_cnt <= '0;
                if (w_wrap) begin
                    r_phase   <= '0;
                    r_duty_sh <= w_duty_req;
                end else begin
                    r_phase <= r_phase + 7'd1;
                end
            end else begin
                r_pre_cnt <= r_pre_cnt + 16'd1;
            end
        end else begin
            r_period_start <= 1'b0;
        end
    end

    assign wave_out     = r_wave;
    assign dac_out      = r_dac;
    assign period_start = r_period_start;
    assign duty_latched = r_duty_sh;

endmodule
`default_nettype wire

// File: tb/tb_duty_cycle_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_duty_cycle_wave_gen
//  Purpose  : Scoreboard bench for duty_cycle_wave_gen against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_duty_cycle_wave_gen;

    localparam int PS    = 100;
    localparam int RDUTY = 50;
    localparam int DHIGH = 4095;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] step_div = '0;
    logic [6:0]  dutyCycle = '0;
    logic        wave_out;
    logic [11:0] dac_out;
    logic        period_start;
    logic [6:0]  duty_latched;

    duty_cycle_wave_gen #(.PHASE_STEPS(PS), .RESET_DUTY(RDUTY), .DAC_HIGH(DHIGH)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .step_div     (step_div),
        .dutyCycle    (dutyCycle),
        .wave_out     (wave_out),
        .dac_out      (dac_out),
        .period_start (period_start),
        .duty_latched (duty_latched)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        wave;
        logic [11:0] dac;
        logic        ps;
        logic [6:0]  duty;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state: prescaler count, phase index, latched duty, registered outputs.
    int m_pre = 0, m_phase = 0, m_duty = RDUTY, m_wave = 0, m_ps = 0;
    bit en_v = 1'b1;
    int sd_v = 0, dc_v = 50;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input int sd, input int dc);
        exp_t e;
        bit   tick;
        @(negedge clock);
        reset     = rst;
        enable    = en;
        step_div  = 16'(sd);
        dutyCycle = 7'(dc);
        if (rst) begin
            m_pre = 0; m_phase = 0; m_duty = RDUTY; m_wave = 0; m_ps = 0;
        end else if (en) begin
            m_wave = (m_phase < m_duty) ? 1 : 0;
            tick   = (m_pre >= sd);
            m_ps   = (tick && m_phase == PS - 1) ? 1 : 0;
            if (tick) begin
                m_pre = 0;
                if (m_phase == PS - 1) begin
                    m_phase = 0;
                    m_duty  = (dc > PS) ? PS : dc;
                end else begin
                    m_phase = m_phase + 1;
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end else begin
            m_ps = 0;
        end
        e.wave = 1'(m_wave);
        e.dac  = (m_wave != 0) ? 12'(DHIGH) : 12'd0;
        e.ps   = 1'(m_ps);
        e.duty = 7'(m_duty);
        sb_q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b0, en_v, sd_v, dc_v);
    endtask

    // Monitor: one scoreboard entry is due after every rising edge.
    initial begin
        exp_t e;
        #1;
        chk("init_wave", int'(wave_out), 0);
        chk("init_dac", int'(dac_out), 0);
        chk("init_period_start", int'(period_start), 0);
        chk("init_duty_latched", int'(duty_latched), RDUTY);
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wave_out", int'(wave_out), int'(e.wave));
                chk("dac_out", int'(dac_out), int'(e.dac));
                chk("period_start", int'(period_start), int'(e.ps));
                chk("duty_latched", int'(duty_latched), int'(e.duty));
            end
        end
    end

    initial begin
        int len;
        int guard;
        repeat (3) cyc(1'b1, 1'b1, 0, 50);

        // Default operation: 100-clock period, half duty.
        en_v = 1; sd_v = 0; dc_v = 50;
        run(250);

        // Slower prescaler, quarter duty across a wrap.
        sd_v = 3; dc_v = 25;
        run(900);

        // Duty change mid-period must wait for the next wrap.
        sd_v = 0; dc_v = 30;
        run(100 - (m_phase));
        run(40);
        dc_v = 70;
        run(160);

        // Duty extremes: stuck low then clamped stuck high.
        dc_v = 0;
        run(100 - m_phase + 100);
        dc_v = 127;
        run(200);

        // Prescaler shrink below the running count.
        dc_v = 50; sd_v = 1000;
        run(500);
        sd_v = 10;
        run(60);

        // Freeze for 37 clocks, then reset mid-period.
        sd_v = 0;
        run(30);
        en_v = 0;
        run(37);
        en_v = 1;
        run(20);
        cyc(1'b1, 1'b1, 0, 50);
        run(120);

        // Randomised segments.
        for (int s = 0; s < 30; s++) begin
            en_v = ($urandom_range(0, 9) != 0);
            sd_v = $urandom_range(0, 5);
            dc_v = $urandom_range(0, 127);
            len  = $urandom_range(1, 250);
            if ($urandom_range(0, 19) == 0) cyc(1'b1, en_v, sd_v, dc_v);
            run(len);
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clock);
            #2;
            guard++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 entries left", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
